// File: rtl/calc_pkg.sv
// Shared calculator definitions: keypad legend map, function key codes and
// the scanner FSM states, plus small bit-vector helpers.
package calc_pkg;

    localparam logic [3:0] KEY_NEG = 4'hA;
    localparam logic [3:0] KEY_EQ  = 4'hB;
    localparam logic [3:0] KEY_ADD = 4'hC;
    localparam logic [3:0] KEY_SUB = 4'hD;
    localparam logic [3:0] KEY_MUL = 4'hE;
    localparam logic [3:0] KEY_DIV = 4'hF;

    // Entry 4*col+row holds the legend printed on that key.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hC, 4'hB, 4'hA,   // col3
        4'hE, 4'h9, 4'h6, 4'h3,   // col2
        4'hF, 4'h8, 4'h5, 4'h2,   // col1
        4'h0, 4'h7, 4'h4, 4'h1    // col0
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_BLOCKED
    } scan_state_e;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
        return n;
    endfunction

    function automatic logic [3:0] first_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
        return idx;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Full-scan snapshot debouncer: a snapshot must repeat on DEBOUNCE_SCANS
// consecutive commits before it is copied into the stable register.
module keypad_debounce #(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_i,
    input  logic [15:0] snap_i,
    output logic [15:0] stable_o,
    output logic        update_o
);
    import calc_pkg::*;

    if (DEBOUNCE_SCANS < 2) begin : g_bad_param
        $fatal(1, "keypad_debounce: DEBOUNCE_SCANS must be >= 2");
    end

    localparam int CW = $clog2(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS - 1);

    logic [15:0]   prev_q, stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          upd_q, upd_d;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        upd_d    = 1'b0;
        if (commit_i) begin
            if (snap_i == prev_q) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            else                  cnt_d = '0;
            if (cnt_d == CNT_MAX) begin
                stable_d = snap_i;
                upd_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
            upd_q    <= 1'b0;
        end else begin
            if (commit_i) prev_q <= snap_i;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            upd_q    <= upd_d;
        end
    end

    assign stable_o = stable_q;
    assign update_o = upd_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column low at a time, samples rows,
// debounces full-scan snapshots and strobes out one hex code per clean press.
module keypad_scanner #(
    parameter int SCAN_CYCLES    = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] col,
    input  logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       multi_key
);
    import calc_pkg::*;

    if (SCAN_CYCLES < 4) begin : g_bad_param
        $fatal(1, "keypad_scanner: SCAN_CYCLES must be >= 4");
    end

    localparam int CW = $clog2(SCAN_CYCLES);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_CYCLES - 1);

    logic [3:0]    row_s1_q, row_s2_q;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [1:0]    col_q, col_d;
    logic [11:0]   work_q, work_d;
    logic          slot_end, commit;
    logic [15:0]   snap, stable;
    logic          stable_upd;
    logic [4:0]    pop;

    scan_state_e   state_q, state_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;

    assign slot_end = (cyc_q == SLOT_LAST);
    assign commit   = slot_end && (col_q == 2'd3);
    // Column 3 is folded in straight from the synchronizer on the commit cycle.
    assign snap     = {~row_s2_q, work_q};

    always_comb begin
        cyc_d  = slot_end ? '0 : cyc_q + 1'b1;
        col_d  = slot_end ? col_q + 2'd1 : col_q;
        work_d = work_q;
        if (slot_end && col_q != 2'd3) work_d[{col_q, 2'b00} +: 4] = ~row_s2_q;
    end

    always_comb begin
        col        = 4'hF;
        col[col_q] = 1'b0;
    end

    keypad_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .commit_i (commit),
        .snap_i   (snap),
        .stable_o (stable),
        .update_o (stable_upd)
    );

    assign pop = popcount16(stable);

    // After an accept, only a full release re-arms the scanner.
    always_comb begin
        state_d     = state_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        if (stable_upd) begin
            case (state_q)
                ST_IDLE: begin
                    if (pop == 5'd1) begin
                        key_code_d  = KEY_MAP[first_set(stable)];
                        key_valid_d = 1'b1;
                        state_d     = ST_PRESSED;
                    end else if (pop > 5'd1) begin
                        state_d = ST_BLOCKED;
                    end
                end
                ST_PRESSED, ST_BLOCKED: if (stable == '0) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1_q    <= 4'hF;
            row_s2_q    <= 4'hF;
            cyc_q       <= '0;
            col_q       <= '0;
            work_q      <= '0;
            state_q     <= ST_IDLE;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
        end else begin
            row_s1_q    <= row;
            row_s2_q    <= row_s1_q;
            cyc_q       <= cyc_d;
            col_q       <= col_d;
            work_q      <= work_d;
            state_q     <= state_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = (state_q == ST_PRESSED);
    assign multi_key = (pop > 5'd1);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad matrix model drives rows from
// the column drive; a monitor pops expected key codes on every key_valid.
module tb_keypad_scanner;
    localparam int SC        = 8;
    localparam int DS        = 3;
    localparam int SCAN      = 4 * SC;
    localparam int ACC_BOUND = 2 + (DS + 1) * SCAN + 1 + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] col, row, key_code;
    logic       key_valid, key_held, multi_key;
    logic [15:0] keys = '0;

    int tests   = 0;
    int fails   = 0;
    int nstrobe = 0;
    logic [3:0] exp_q[$];

    keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_SCANS(DS)) dut (
        .clk       (clk),
        .rst       (rst),
        .col       (col),
        .row       (row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .multi_key (multi_key)
    );

    always #5 clk = ~clk;

    // Matrix model: a pressed key shorts its row to its driven-low column.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            if (!col[c]) row = row & ~keys[4*c +: 4];
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            nstrobe++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected strobe: got code %0h expected no strobe", key_code);
            end else begin
                check("strobe code", int'(key_code), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_strobe(input int base, input string name);
        int n = 0;
        while (nstrobe == base && n < ACC_BOUND) begin
            @(negedge clk); #1;
            n++;
        end
        check(name, int'(nstrobe != base), 1);
    endtask

    task automatic wait_held_low(input string name);
        int n = 0;
        while (key_held && n < ACC_BOUND) begin
            @(negedge clk); #1;
            n++;
        end
        check(name, int'(key_held), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   base;
        logic ok;
        logic [3:0] ecol;

        // Reset values and column sequence
        cycles(3);
        check("rst col", int'(col), 'hE);
        check("rst key_code", int'(key_code), 0);
        check("rst key_valid", int'(key_valid), 0);
        check("rst key_held", int'(key_held), 0);
        check("rst multi_key", int'(multi_key), 0);
        rst = 1'b0;
        for (int k = 0; k <= 32; k += 4) begin
            ecol = 4'hF;
            ecol[(k / 8) % 4] = 1'b0;
            check("col seq", int'(col), int'(ecol));
            cycles(4);
        end

        // Key 5: single accept, held, no repeat, release
        base = nstrobe;
        exp_q.push_back(4'h5);
        keys[5] = 1'b1;
        wait_strobe(base, "key5 accept");
        check("key5 held at accept", int'(key_held), 1);
        ok = 1'b1;
        repeat (3 * SCAN) begin
            @(negedge clk);
            if (key_held !== 1'b1) ok = 1'b0;
        end
        check("key5 held throughout", int'(ok), 1);
        check("key5 strobe count", nstrobe - base, 1);
        keys = '0;
        wait_held_low("key5 release");

        // Bouncing A then steady
        base = nstrobe;
        exp_q.push_back(4'hA);
        for (int i = 0; i < 10; i++) begin
            keys[12] = ~keys[12];
            cycles(20);
        end
        keys[12] = 1'b1;
        if (nstrobe == base) wait_strobe(base, "keyA accept");
        cycles(2 * SCAN);
        check("keyA strobe count", nstrobe - base, 1);
        check("keyA code", int'(key_code), 'hA);
        keys = '0;
        wait_held_low("keyA release");

        // Keys 1+2 together blocked, then 9
        base = nstrobe;
        keys[0] = 1'b1;
        keys[4] = 1'b1;
        cycles(ACC_BOUND);
        check("multi set", int'(multi_key), 1);
        check("multi not held", int'(key_held), 0);
        check("multi no strobe", nstrobe - base, 0);
        keys = '0;
        cycles(ACC_BOUND);
        check("multi cleared", int'(multi_key), 0);
        exp_q.push_back(4'h9);
        keys[10] = 1'b1;
        wait_strobe(base, "key9 accept");
        check("key9 multi", int'(multi_key), 0);
        check("key9 code", int'(key_code), 'h9);
        keys = '0;
        wait_held_low("key9 release");

        // Key D for one scan only
        base = nstrobe;
        keys[15] = 1'b1;
        cycles(SCAN);
        keys = '0;
        cycles(ACC_BOUND);
        check("short D no strobe", nstrobe - base, 0);
        check("short D code kept", int'(key_code), 'h9);

        // Key 0, reset mid-hold, accepted again after release
        base = nstrobe;
        exp_q.push_back(4'h0);
        keys[3] = 1'b1;
        wait_strobe(base, "key0 accept");
        cycles(SC + 3);
        #2 rst = 1'b1;
        #1;
        check("async rst col", int'(col), 'hE);
        check("async rst held", int'(key_held), 0);
        check("async rst valid", int'(key_valid), 0);
        check("async rst code", int'(key_code), 0);
        cycles(3);
        rst = 1'b0;
        base = nstrobe;
        exp_q.push_back(4'h0);
        wait_strobe(base, "key0 re-accept");
        check("key0 held after rst", int'(key_held), 1);
        check("key0 code", int'(key_code), 0);
        keys = '0;
        wait_held_low("key0 release");
        cycles(SCAN);
        check("scoreboard drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
